oled_spi_responder: RTL and testbench

//  Display-side receiver for the PmodOLED 4-wire SPI link (SSD1306-style, write-only, mode 0/3, MSB first).

---
 rtl/oled_spi_responder.sv | 181 ++++++++++++++++++
 tb/tb_oled_spi_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_responder.sv
// PmodOLED SPI receiver: oversampled byte capture, command/data FIFO,
// panel power-sequence tracking and sticky protocol-violation flags.
module oled_spi_responder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int MIN_RES_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oled_cs,
  input  logic       oled_sclk,
  input  logic       oled_sdin,
  input  logic       oled_dc,
  input  logic       oled_res,
  input  logic       oled_vdd,
  input  logic       oled_vbat,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [2:0] pwr_state,
  output logic       display_on,
  output logic       overflow,
  output logic       frame_err,
  output logic       seq_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MIN_RES_CYCLES + 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MIN_W = CW'(MIN_RES_CYCLES);

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    VDD_ON = 3'd1,
    IN_RES = 3'd2,
    READY  = 3'd3,
    LIT    = 3'd4
  } pwr_t;

  pwr_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  // {vbat, vdd, res, dc, sdin, sclk, cs}; reset to the idle/unpowered levels
  localparam logic [6:0] IDLE = 7'b1110001;
  logic [6:0] s1, s2;
  logic sclk_d;

  logic [6:0] shreg;
  logic [2:0] bitcnt;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;

  logic cs_s, sclk_s, sdin_s, dc_s, res_s, vdd_s, vbat_s;
  logic rise, byte_done, full, pop, push_ok, flush;
  logic [7:0] new_byte;
  logic [8:0] head;

  assign cs_s   = s2[0];
  assign sclk_s = s2[1];
  assign sdin_s = s2[2];
  assign dc_s   = s2[3];
  assign res_s  = s2[4];
  assign vdd_s  = s2[5];
  assign vbat_s = s2[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= IDLE;
      s2     <= IDLE;
      sclk_d <= 1'b0;
    end else begin
      s1     <= {oled_vbat, oled_vdd, oled_res, oled_dc,
                 oled_sdin, oled_sclk, oled_cs};
      s2     <= s1;
      sclk_d <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (vdd_s) begin
      state_n = OFF;
    end else begin
      unique case (state)
        OFF:    state_n = VDD_ON;
        VDD_ON: if (!res_s) begin
          state_n = IN_RES;
          cnt_n   = CW'(1);
        end
        IN_RES: if (res_s) begin
          state_n = (cnt >= MIN_W) ? READY : VDD_ON;
        end else if (cnt < MIN_W) begin
          cnt_n = cnt + CW'(1);
        end
        READY: if (!res_s) begin
          state_n = IN_RES;
          cnt_n   = CW'(1);
        end else if (!vbat_s) begin
          state_n = LIT;
        end
        LIT: if (!res_s) begin
          state_n = IN_RES;
          cnt_n   = CW'(1);
        end else if (vbat_s) begin
          state_n = READY;
        end
        default: state_n = OFF;
      endcase
    end
  end

  assign rise      = sclk_s & ~sclk_d;
  assign byte_done = rise & ~cs_s & (bitcnt == 3'd7);
  assign new_byte  = {shreg, sdin_s};
  assign flush     = vdd_s | (state_n == IN_RES && state != IN_RES);
  assign full      = (count == FULL);
  assign rx_valid  = (count != '0);
  assign pop       = rx_valid & rx_ready;
  assign push_ok   = byte_done & (~full | pop) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      bitcnt     <= '0;
      wr         <= '0;
      rd         <= '0;
      count      <= '0;
      display_on <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      seq_err    <= 1'b0;
    end else if (flush) begin
      bitcnt     <= '0;
      wr         <= '0;
      rd         <= '0;
      count      <= '0;
      display_on <= 1'b0;
    end else begin
      if (cs_s) begin
        bitcnt <= '0;
        if (bitcnt != 3'd0) frame_err <= 1'b1;
      end else if (rise) begin
        shreg  <= new_byte[6:0];
        bitcnt <= bitcnt + 3'd1;
      end
      if (pop) rd <= rd + AW'(1);
      if (push_ok) wr <= wr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (byte_done && full && !pop) overflow <= 1'b1;
      if (byte_done && state != READY && state != LIT) seq_err <= 1'b1;
      if (byte_done && !dc_s) begin
        if (new_byte == 8'hAF) display_on <= 1'b1;
        else if (new_byte == 8'hAE) display_on <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr] <= {dc_s, new_byte};
  end

  assign head      = mem[rd];
  assign rx_data   = rx_valid ? head[7:0] : 8'h00;
  assign rx_dc     = rx_valid & head[8];
  assign pwr_state = state;
endmodule

// File: tb/tb_oled_spi_responder.sv
// Directed power/SPI sequences plus randomized byte bursts, checked
// against a queue-based model of the receiver.
module tb_oled_spi_responder;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs = 1'b1, sclk = 1'b0, sdin = 1'b0, dc = 1'b0;
  logic res = 1'b1, vdd = 1'b1, vbat = 1'b1;
  logic rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_dc, rx_valid, display_on, overflow, frame_err, seq_err;
  logic [2:0] pwr_state;

  int checks = 0;
  int errors = 0;

  logic [8:0] q[$];
  bit disp_m = 0;
  bit ov_m = 0;
  bit seq_m = 0;
  int pwr_m = 0;

  oled_spi_responder #(.FIFO_DEPTH(DEPTH), .MIN_RES_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .oled_cs(cs), .oled_sclk(sclk), .oled_sdin(sdin), .oled_dc(dc),
    .oled_res(res), .oled_vdd(vdd), .oled_vbat(vbat),
    .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pwr_state(pwr_state),
    .display_on(display_on), .overflow(overflow),
    .frame_err(frame_err), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    for (int i = 7; i >= 0; i--) begin
      sdin = b[i];
      dc = d;
      clks(4);
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
    end
    clks(2);
    if (q.size() < DEPTH) q.push_back({d, b});
    else ov_m = 1;
    if (pwr_m != 3 && pwr_m != 4) seq_m = 1;
    if (!d && b == 8'hAF) disp_m = 1;
    else if (!d && b == 8'hAE) disp_m = 0;
  endtask

  task automatic drain(input string tag);
    logic [8:0] e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_valid"}, rx_valid, 1);
      chk({tag, "_byte"}, {rx_dc, rx_data}, e);
      rx_ready = 1'b1;
      clks(1);
      rx_ready = 1'b0;
    end
    chk({tag, "_empty"}, rx_valid, 0);
  endtask

  initial begin
    int n, w;
    clks(3);
    chk("rst_data", {rx_dc, rx_data}, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_flags", {display_on, overflow, frame_err, seq_err}, 0);
    chk("rst_pwr", pwr_state, 0);
    rst = 1'b0;
    clks(4);
    chk("off_pwr", pwr_state, 0);

    vdd = 1'b0;
    clks(4);
    chk("vdd_on", pwr_state, 1);
    res = 1'b0;
    clks(4);
    chk("in_res", pwr_state, 2);
    clks(6);
    res = 1'b1;
    clks(4);
    chk("ready", pwr_state, 3);
    vbat = 1'b0;
    clks(4);
    chk("lit", pwr_state, 4);
    chk("pwrup_seq", seq_err, 0);
    pwr_m = 4;

    cs = 1'b0;
    clks(3);
    send_byte(8'hAF, 1'b0);
    send_byte(8'h5A, 1'b1);
    cs = 1'b1;
    clks(4);
    chk("disp_on", display_on, 1);
    drain("bytes");

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, DEPTH);
      cs = 1'b0;
      clks(3);
      for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'($urandom));
      cs = 1'b1;
      clks(4);
      chk("rnd_disp", display_on, disp_m);
      chk("rnd_ovf", overflow, 0);
      drain("rnd");
    end

    cs = 1'b0;
    clks(3);
    for (int i = 0; i < 5; i++) begin
      sdin = 1'($urandom);
      clks(4);
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
    end
    clks(2);
    cs = 1'b1;
    clks(4);
    chk("frame_err", frame_err, 1);
    chk("frame_nopush", rx_valid, 0);
    cs = 1'b0;
    clks(3);
    send_byte(8'h3C, 1'b1);
    cs = 1'b1;
    clks(4);
    drain("after_frame");

    cs = 1'b0;
    clks(3);
    for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b1);
    cs = 1'b1;
    clks(4);
    chk("overflow", overflow, ov_m);
    drain("ovf");

    cs = 1'b0;
    clks(3);
    send_byte(8'hAF, 1'b0);
    cs = 1'b1;
    clks(4);
    chk("pre_short_disp", display_on, 1);
    chk("pre_short_seq", seq_err, 0);
    w = $urandom_range(1, 3);
    res = 1'b0;
    clks(w);
    res = 1'b1;
    clks(5);
    q.delete();
    disp_m = 0;
    pwr_m = 1;
    chk("short_pwr", pwr_state, 1);
    chk("short_disp", display_on, disp_m);
    chk("short_flush", rx_valid, 0);
    cs = 1'b0;
    clks(3);
    send_byte(8'h81, 1'b0);
    cs = 1'b1;
    clks(4);
    chk("seq_err", seq_err, seq_m);
    drain("seq");

    w = $urandom_range(4, 12);
    res = 1'b0;
    clks(w);
    res = 1'b1;
    clks(5);
    pwr_m = 4;
    chk("rereset_pwr", pwr_state, 4);

    cs = 1'b0;
    clks(3);
    send_byte(8'hAF, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    cs = 1'b1;
    clks(4);
    chk("drop_disp_pre", display_on, 1);
    chk("drop_valid_pre", rx_valid, 1);
    vdd = 1'b1;
    clks(4);
    chk("drop_pwr", pwr_state, 0);
    chk("drop_valid", rx_valid, 0);
    chk("drop_disp", display_on, 0);
    q.delete();

    vdd = 1'b0;
    cs = 1'b0;
    clks(3);
    for (int i = 0; i < 3; i++) begin
      clks(4);
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
    end
    clks(2);
    rst = 1'b1;
    #1;
    chk("arst_flags", {overflow, frame_err, seq_err}, 0);
    chk("arst_pwr", pwr_state, 0);
    clks(2);
    rst = 1'b0;
    cs = 1'b1;
    clks(5);
    chk("arst_bitcnt", frame_err, 0);
    chk("arst_vdd", pwr_state, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
